// File: rtl/gap_junction_stream_gen.sv
// gap_junction_stream_gen: AXI-Stream packet generator.
// After a start delay counted in sink-ready cycles, emits packets of PKT_LEN
// words (one HEADER word followed by PAYLOAD words), optionally separated by
// GAP idle cycles, until NUM_PKTS packets are sent (0 = run forever).
// Optional feature macro: GJ_STREAM_GEN_RAMP_EN -- payload word k carries
// PAYLOAD+k-1 instead of a constant PAYLOAD.
// All stream outputs come straight from flops; TREADY only feeds next-state
// logic, so there is no combinational path from TREADY to any output.

module gap_junction_stream_gen #(
  parameter int          DATA_W      = 32,
  parameter int          PKT_LEN     = 217,
  parameter logic [31:0] HEADER      = 32'h0200_0360,
  parameter logic [31:0] PAYLOAD     = 32'hc270_0000,
  parameter int          START_DELAY = 20000,
  parameter int          NUM_PKTS    = 1,
  parameter int          GAP         = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              input_r_TVALID_0,
  input  logic              input_r_TREADY_0,
  output logic [DATA_W-1:0] input_r_TDATA_0,
  output logic              input_r_TLAST_0,
  output logic [15:0]       pkt_count,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  // Header/payload constants resized to the stream width (zero-extend or truncate).
  localparam logic [DATA_W-1:0] HEADER_W   = DATA_W'(HEADER);
  localparam logic [DATA_W-1:0] PAYLOAD_W  = DATA_W'(PAYLOAD);
  localparam logic [19:0]       DELAY_END  = 20'(START_DELAY);
  localparam logic [15:0]       LAST_IDX   = 16'(PKT_LEN - 1);
  // Only used when GAP > 0; wraps harmlessly otherwise.
  localparam logic [15:0]       GAP_END    = 16'(GAP - 1);
  localparam logic [16:0]       NUM_PKTS_W = 17'(NUM_PKTS);
  localparam bit                HAS_GAP    = (GAP > 0);
  localparam bit                CONTINUOUS = (NUM_PKTS == 0);

  state_t      state;
  state_t      state_next;
  logic [19:0] delay_cnt;
  logic [19:0] delay_cnt_next;
  logic [15:0] word_idx;
  logic [15:0] word_idx_next;
  logic [15:0] gap_cnt;
  logic [15:0] gap_cnt_next;
  logic [15:0] pkt_count_next;
  logic [16:0] pkt_count_inc;
  logic        tready_q;
  logic        xfer;
  logic        last_word;

  logic              tvalid_d;
  logic              tlast_d;
  logic [DATA_W-1:0] tdata_d;
  logic [DATA_W-1:0] payload_word;
  logic              done_d;

  assign xfer          = input_r_TVALID_0 & input_r_TREADY_0;
  assign last_word     = (word_idx == LAST_IDX);
  assign pkt_count_inc = {1'b0, pkt_count} + 17'd1;

`ifdef GJ_STREAM_GEN_RAMP_EN
  // Payload word k carries PAYLOAD + (k-1), wrapping at the stream width.
  logic [DATA_W-1:0] ramp_off;
  assign ramp_off     = DATA_W'(word_idx_next - 16'd1);
  assign payload_word = PAYLOAD_W + ramp_off;
`else
  // Constant payload; no ramp arithmetic in this build.
  assign payload_word = PAYLOAD_W;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (!reset) begin
      state <= ST_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_next     = state;
    delay_cnt_next = delay_cnt;
    word_idx_next  = word_idx;
    gap_cnt_next   = gap_cnt;
    pkt_count_next = pkt_count;

    case (state)
      ST_WAIT: begin
        if (delay_cnt == DELAY_END) begin
          state_next = ST_SEND;
        end else if (tready_q) begin
          delay_cnt_next = delay_cnt + 20'd1;
        end
      end

      ST_SEND: begin
        if (xfer) begin
          if (last_word) begin
            word_idx_next = '0;
            if (pkt_count != 16'hFFFF) begin
              pkt_count_next = pkt_count + 16'd1;
            end
            if (!CONTINUOUS && (pkt_count_inc == NUM_PKTS_W)) begin
              state_next = ST_DONE;
            end else if (HAS_GAP) begin
              state_next   = ST_GAP;
              gap_cnt_next = '0;
            end else begin
              state_next = ST_SEND;
            end
          end else begin
            word_idx_next = word_idx + 16'd1;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_END) begin
          state_next = ST_SEND;
        end else begin
          gap_cnt_next = gap_cnt + 16'd1;
        end
      end

      ST_DONE: begin
        state_next = ST_DONE;
      end

      default: begin
        state_next = ST_WAIT;
      end
    endcase
  end

  // Output decode: values the output flops load at the next edge.
  always_comb begin
    tvalid_d = (state_next == ST_SEND);
    tlast_d  = tvalid_d && (word_idx_next == LAST_IDX);
    tdata_d  = '0;
    if (tvalid_d) begin
      tdata_d = (word_idx_next == 16'd0) ? HEADER_W : payload_word;
    end
    done_d = (state_next == ST_DONE);
  end

  // Datapath counters and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      delay_cnt        <= '0;
      word_idx         <= '0;
      gap_cnt          <= '0;
      tready_q         <= 1'b0;
      pkt_count        <= '0;
      input_r_TVALID_0 <= 1'b0;
      input_r_TLAST_0  <= 1'b0;
      input_r_TDATA_0  <= '0;
      done             <= 1'b0;
    end else begin
      delay_cnt        <= delay_cnt_next;
      word_idx         <= word_idx_next;
      gap_cnt          <= gap_cnt_next;
      tready_q         <= input_r_TREADY_0;
      pkt_count        <= pkt_count_next;
      input_r_TVALID_0 <= tvalid_d;
      input_r_TLAST_0  <= tlast_d;
      input_r_TDATA_0  <= tdata_d;
      done             <= done_d;
    end
  end

endmodule

// File: doc/gap_junction_stream_gen.md
GAP_JUNCTION_STREAM_GEN -- requirements
Module: gap_junction_stream_gen

Interface
REQ-001 Parameter DATA_W, default 32: stream data width in bits, legal 8..64.
REQ-002 Parameter PKT_LEN, default 217: words per packet including header, legal 2..65535.
REQ-003 Parameter HEADER, default 32'h02000360: first word of each packet, zero-extended or truncated to DATA_W.
REQ-004 Parameter PAYLOAD, default 32'hc2700000: value of words 1..PKT_LEN-1.
REQ-005 Parameter START_DELAY, default 20000: sink-ready cycles before the first packet, legal 0..2^20-1.
REQ-006 Parameter NUM_PKTS, default 1: packets to send; 0 means continuous.
REQ-007 Parameter GAP, default 0: idle cycles between packets, legal 0..65535.
REQ-008 clk  input  1  sole clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-low reset.
REQ-010 input_r_TVALID_0  output  1  AXI-Stream valid.
REQ-011 input_r_TREADY_0  input  1  AXI-Stream ready from sink.
REQ-012 input_r_TDATA_0  output  DATA_W  AXI-Stream data.
REQ-013 input_r_TLAST_0  output  1  high on the final word of each packet.
REQ-014 pkt_count  output  16  packets fully transferred, saturating at 16'hFFFF.
REQ-015 done  output  1  high once NUM_PKTS packets are sent; never high when NUM_PKTS=0.

Function
REQ-016 FSM states: WAIT, SEND, GAP, DONE; reset enters WAIT.
REQ-017 WAIT: 20-bit delay counter increments on each cycle with input_r_TREADY_0 registered high; on count reaching START_DELAY, go to SEND next cycle; START_DELAY=0 enters SEND on the first cycle after reset release.
REQ-018 SEND: TVALID high; word index 0 presents HEADER, indices 1..PKT_LEN-1 present PAYLOAD.
REQ-019 Transfer occurs only on a cycle with TVALID and TREADY both high; word index advances by one per transfer.
REQ-020 While TVALID is high and TREADY low, TDATA, TLAST and TVALID hold stable.
REQ-021 TLAST is high exactly when word index equals PKT_LEN-1.
REQ-022 On the TLAST transfer: pkt_count increments, word index returns to 0; next state DONE if pkt_count+1 equals NUM_PKTS (NUM_PKTS!=0), else GAP if GAP>0, else SEND, giving back-to-back packets with no bubble.
REQ-023 GAP: TVALID low for exactly GAP cycles, then SEND.
REQ-024 DONE: TVALID low, done high, state held until reset.
REQ-025 All stream outputs are registered; no combinational path from TREADY to any output.

Reset
REQ-026 When reset is low at a rising edge: TVALID=0, TLAST=0, TDATA=0, pkt_count=0, done=0, delay counter=0, word index=0, state=WAIT.
REQ-027 Reset asserted mid-packet aborts the packet without TLAST; after release a full START_DELAY wait precedes a fresh packet starting with HEADER.

Configuration
REQ-028 Macro GJ_STREAM_GEN_RAMP_EN defined: payload word k (k=1..PKT_LEN-1) equals PAYLOAD+k-1 modulo 2^DATA_W; header unchanged.
REQ-029 Macro GJ_STREAM_GEN_RAMP_EN undefined: every payload word equals PAYLOAD; no ramp adder is synthesised.

Verification
REQ-030 Defaults, TREADY tied high: first TVALID after 20000 ready cycles plus pipeline latency; 217 words, word0=02000360, words1..216=c2700000, TLAST only on word 216, done=1, pkt_count=1.
REQ-031 START_DELAY=0, PKT_LEN=4, NUM_PKTS=3, GAP=0, TREADY high -> 12 consecutive valid cycles, TLAST on words 3,7,11, pkt_count=3, done=1.
REQ-032 PKT_LEN=8, TREADY toggling 1,0,1,0 -> every word transferred exactly once in order, outputs stable during TREADY-low cycles.
REQ-033 GAP=5, NUM_PKTS=2, PKT_LEN=4 -> exactly 5 TVALID-low cycles between TLAST of packet 1 and HEADER of packet 2.
REQ-034 Reset driven low at word 100 of a 217-word packet -> all outputs 0 next cycle; after release, new packet begins with HEADER, no TLAST emitted for the aborted one.
REQ-035 GJ_STREAM_GEN_RAMP_EN defined, PAYLOAD=FFFFFFFE, PKT_LEN=4 -> words 02000360, FFFFFFFE, FFFFFFFF, 00000000.
